pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_pkg.sv | 30 +++
 rtl/pixel_writer_packer.sv | 51 +++++
 rtl/pixel_writer.sv | 175 +++++++++++++++++
 tb/tb_pixel_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared geometry defaults, state encoding and the downscale keep rule
// for the pixel writer.
package pixel_writer_pkg;

  localparam int FACTOR_DEF  = 2;
  localparam int HEIGHT_DEF  = 30;
  localparam int WIDTH_DEF   = 30;
  localparam int BPP_DEF     = 3;
  localparam int PIXELS_DEF  = HEIGHT_DEF * WIDTH_DEF;
  localparam int ADDR_SH_DEF = PIXELS_DEF / (FACTOR_DEF ** 2);
  localparam int ADDR_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // In shrink mode only the top-left pixel of each FACTOR x FACTOR block survives.
  function automatic logic keep_pixel(input logic sh, input int row, input int col,
                                      input int factor);
    if (!sh) begin
      return 1'b1;
    end else begin
      return ((row % factor) == 0) && ((col % factor) == 0);
    end
  endfunction

endpackage

// File: rtl/pixel_writer_packer.sv
// Byte counter plus shift register: gathers BPP bytes, first byte ending up
// in the most significant position of the pixel word.
module pixel_packer
  import pixel_writer_pkg::*;
#(
  parameter int BPP = BPP_DEF
) (
  input  logic           wr_clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           accept,
  input  logic [7:0]     in_data,
  output logic           last,
  output logic [8*BPP-1:0] pixel
);

  localparam int CNT_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int PIX_W = 8 * BPP;

  logic [CNT_W-1:0] cnt_q, cnt_d, idx_s;
  logic [PIX_W-1:0] shreg_q, shreg_d, base_s;

  // Next byte index, assembled pixel and register updates.
  always_comb begin
    idx_s   = clear ? '0 : cnt_q;
    base_s  = clear ? '0 : shreg_q;
    last    = (idx_s == CNT_W'(BPP - 1));
    pixel   = (base_s << 8) | PIX_W'(in_data);
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      cnt_d   = last ? '0 : idx_s + 1'b1;
      shreg_d = pixel;
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  // Byte counter and shift register state.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Packs an incoming byte stream into pixels and writes them to a frame
// buffer, optionally downscaling by FACTOR in both dimensions.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int FACTOR  = FACTOR_DEF,
  parameter int HEIGHT  = HEIGHT_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int BPP     = BPP_DEF,
  parameter int PIXELS  = HEIGHT * WIDTH,
  parameter int ADDR_SH = PIXELS / (FACTOR ** 2)
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              sh_en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8*BPP-1:0]  write_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (((HEIGHT % FACTOR) != 0) || ((WIDTH % FACTOR) != 0) ||
      (PIXELS > (1 << ADDR_W)) || ((ADDR_SH * FACTOR * FACTOR) != PIXELS)) begin : g_param_check
    $error("pixel_writer: frame geometry does not fit the buffer or the downscale factor");
  end

  state_e            state_q, state_d;
  logic              sh_q, sh_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [8*BPP-1:0]  write_data_q, write_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic              accept_s, start_s, keep_s, pk_last_s;
  logic [8*BPP-1:0]  pk_pixel_s;

  assign in_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_COLLECT));
  assign accept_s = in_valid & in_ready;
  assign start_s  = accept_s & (state_q == ST_IDLE);

  pixel_packer #(.BPP(BPP)) u_packer (
    .wr_clk  (wr_clk),
    .rst     (rst),
    .clear   (start_s),
    .accept  (accept_s),
    .in_data (in_data),
    .last    (pk_last_s),
    .pixel   (pk_pixel_s)
  );

  // Frame sequencing, position tracking and write decision.
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    row_d        = row_q;
    col_d        = col_q;
    out_cnt_d    = out_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    write_data_d = write_data_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    keep_s       = keep_pixel(sh_q, int'(row_q), int'(col_q), FACTOR);

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          sh_d      = sh_en;
          row_d     = '0;
          col_d     = '0;
          out_cnt_d = '0;
          busy_d    = 1'b1;
          if (pk_last_s) begin
            // Single-byte pixels: pixel (0,0) is kept in either mode.
            state_d      = ST_EMIT;
            wr_en_d      = 1'b1;
            wr_addr_d    = '0;
            write_data_d = pk_pixel_s;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s && pk_last_s) begin
          state_d      = ST_EMIT;
          wr_en_d      = keep_s;
          write_data_d = pk_pixel_s;
          if (keep_s) begin
            wr_addr_d = out_cnt_q;
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        if (keep_s) begin
          out_cnt_d = out_cnt_q + 1'b1;
        end else begin
          out_cnt_d = out_cnt_q;
        end
        if (col_q == COL_W'(WIDTH - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(HEIGHT - 1)) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_COLLECT;
          end
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sh_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      out_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      write_data_q <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_cnt_q    <= out_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      write_data_q <= write_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign write_data = write_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Randomized bench for pixel_writer: a pixel-level reference model predicts
// every write, frame_done, busy and in_ready cycle by cycle.
module tb_pixel_writer;

  localparam int FACTOR  = 2;
  localparam int HEIGHT  = 30;
  localparam int WIDTH   = 30;
  localparam int BPP     = 3;
  localparam int PIXELS  = HEIGHT * WIDTH;
  localparam int ADDR_SH = PIXELS / (FACTOR * FACTOR);
  localparam int NBYTES  = PIXELS * BPP;

  logic             wr_clk = 1'b0;
  logic             rst = 1'b1;
  logic             sh_en = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_ready, wr_en, frame_done, busy;
  logic [9:0]       wr_addr;
  logic [8*BPP-1:0] write_data;

  pixel_writer #(
    .FACTOR(FACTOR), .HEIGHT(HEIGHT), .WIDTH(WIDTH), .BPP(BPP)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .sh_en      (sh_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .write_data (write_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (written only by the monitor).
  bit               m_in_frame, m_sh, exp_we, exp_ready, busy_exp, emit;
  int               m_pix_idx, m_bcnt, m_kept, done_cd, row, col;
  logic [8*BPP-1:0] m_pix, exp_data, first_wdata;
  logic [9:0]       exp_addr;
  int               total_writes = 0;
  int               total_dones = 0;

  logic [7:0]       frame_bytes [NBYTES];

  always @(negedge wr_clk) begin
    if (rst) begin
      m_in_frame = 1'b0; m_sh = 1'b0; m_pix_idx = 0; m_bcnt = 0; m_kept = 0;
      m_pix = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      exp_ready = 1'b1; busy_exp = 1'b0; done_cd = 0;
    end else begin
      check_eq("wr_en", wr_en, exp_we);
      if (exp_we) check_eq("write_data", write_data, exp_data);
      check_eq("wr_addr", wr_addr, exp_addr);
      check_eq("frame_done", frame_done, done_cd == 1);
      check_eq("busy", busy, busy_exp);
      check_eq("in_ready", in_ready, exp_ready);
      if (wr_en) begin
        total_writes++;
        if (wr_addr == 10'd0) first_wdata = write_data;
      end
      if (frame_done) total_dones++;

      emit   = 1'b0;
      exp_we = 1'b0;
      if (done_cd == 1) busy_exp = 1'b0;
      if (done_cd > 0) done_cd--;
      if (in_valid && exp_ready) begin
        if (!m_in_frame) begin
          m_in_frame = 1'b1; m_sh = sh_en; m_pix_idx = 0; m_kept = 0; m_bcnt = 0;
          busy_exp = 1'b1;
        end
        m_pix = (m_pix << 8) | in_data;
        m_bcnt++;
        if (m_bcnt == BPP) begin
          row = m_pix_idx / WIDTH;
          col = m_pix_idx % WIDTH;
          emit = 1'b1;
          m_bcnt = 0;
          if (!m_sh || ((row % FACTOR) == 0 && (col % FACTOR) == 0)) begin
            exp_we   = 1'b1;
            exp_addr = 10'(m_kept);
            exp_data = m_pix;
            m_kept++;
          end
          m_pix_idx++;
          if (m_pix_idx == PIXELS) begin
            done_cd    = 2;
            m_in_frame = 1'b0;
          end
        end
      end
      exp_ready = !emit && (done_cd != 1);
    end
  end

  // mode 0: valid always high, 1: valid every other cycle, 2: random valid.
  task automatic drive_bytes(input int n, input int mode, input bit toggle_sh);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    for (int i = 0; i < n; i++) frame_bytes[i] = 8'($urandom);
    while (idx < n && cyc < n * 4 + 200) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((cyc % 2) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = frame_bytes[idx];
      if (toggle_sh && idx > 0) sh_en = 1'($urandom_range(0, 1));
      @(negedge wr_clk);
      acc = in_valid && in_ready;
      @(posedge wr_clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bytes_accepted", idx, n);
  endtask

  task automatic finish_frame(input string tag, input int w0, input int exp_w,
                              input int exp_last, input int exp_done);
    repeat (6) @(posedge wr_clk);
    #1;
    check_eq({tag, "_writes"}, total_writes - w0, exp_w);
    check_eq({tag, "_last_addr"}, wr_addr, exp_last);
    check_eq({tag, "_dones"}, total_dones, exp_done);
    check_eq({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge wr_clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge wr_clk);
    @(negedge wr_clk);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
  endtask

  int w0;

  initial begin
    do_reset();

    // Full-size frame, continuous stream.
    w0 = total_writes; sh_en = 1'b0;
    drive_bytes(NBYTES, 0, 1'b0);
    finish_frame("A", w0, PIXELS, PIXELS - 1, 1);
    check_eq("A_first_pixel", first_wdata, {frame_bytes[0], frame_bytes[1], frame_bytes[2]});

    // Shrunk frame, random valid.
    w0 = total_writes; sh_en = 1'b1;
    drive_bytes(NBYTES, 2, 1'b0);
    finish_frame("B", w0, ADDR_SH, ADDR_SH - 1, 2);
    check_eq("B_first_pixel", first_wdata, {frame_bytes[0], frame_bytes[1], frame_bytes[2]});

    // Full-size mode latched, sh_en wiggled mid-frame, valid every other cycle.
    w0 = total_writes; sh_en = 1'b0;
    drive_bytes(NBYTES, 1, 1'b1);
    finish_frame("C", w0, PIXELS, PIXELS - 1, 3);

    // Shrink mode latched, sh_en wiggled mid-frame.
    w0 = total_writes; sh_en = 1'b1;
    drive_bytes(NBYTES, 0, 1'b1);
    finish_frame("D", w0, ADDR_SH, ADDR_SH - 1, 4);

    // Abort a frame after 400 bytes.
    sh_en = 1'b0;
    drive_bytes(400, 0, 1'b0);
    do_reset();
    repeat (4) @(posedge wr_clk);
    #1;
    check_eq("abort_no_done", total_dones, 4);
    check_eq("abort_addr", wr_addr, 0);

    // Fresh frame after the abort restarts at address 0.
    w0 = total_writes; sh_en = 1'b1;
    drive_bytes(NBYTES, 2, 1'b0);
    finish_frame("F", w0, ADDR_SH, ADDR_SH - 1, 5);
    check_eq("F_first_pixel", first_wdata, {frame_bytes[0], frame_bytes[1], frame_bytes[2]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
